// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, branch resolve, wait-stated data RAM, MEM/WB register.
// Optional alignment fault checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] branchAdr,
  input  logic        zero,
  input  logic [31:0] ALUres,
  input  logic [31:0] reg21,
  input  logic [4:0]  writeReg,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  output logic        stall,
  output logic        pcSrc,
  output logic [31:0] branchTarget,
  output logic [31:0] readData,
  output logic [31:0] aluResOut,
  output logic [4:0]  writeRegOut,
  output logic        RegWriteOut,
  output logic        MemtoRegOut,
  output logic        misaligned
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic [31:0] branch_adr;
    logic        zero;
    logic [31:0] alu_res;
    logic [31:0] reg21;
    logic [4:0]  write_reg;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        memto_reg;
  } ex_t;

  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_res;
    logic [4:0]  write_reg;
    logic        reg_write;
    logic        memto_reg;
    logic        misaligned;
  } wb_t;

  ex_t         ex_d, ex_q;
  wb_t         wb_d, wb_q;
  state_t      state_d, state_q;
  logic [3:0]  cnt_d, cnt_q;
  logic        stall_c;
  logic        mem_op;
  logic        fault;
  logic        ram_we;
  logic [AW-1:0] word_addr;
  logic [31:0] ram_rdata;
  logic [31:0] ram [DEPTH];

  assign mem_op    = ex_q.mem_read | ex_q.mem_write;
  assign word_addr = ex_q.alu_res[AW+1:2];
  assign ram_rdata = ram[word_addr];

`ifdef MEM_ALIGN_CHECK_EN
  assign fault = mem_op & (ex_q.alu_res[1:0] != 2'b00);
`else
  assign fault = 1'b0;
`endif

  // The access completes in the one cycle where the entry is not stalled.
  assign ram_we = ex_q.mem_write & ~stall_c & ~fault;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op && LAT != 4'd0) begin
          stall_c = 1'b1;
          state_d = S_WAIT;
          cnt_d   = 4'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q < LAT) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 4'd1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    ex_d = ex_q;
    if (!stall_c) begin
      ex_d.branch_adr = branchAdr;
      ex_d.zero       = zero;
      ex_d.alu_res    = ALUres;
      ex_d.reg21      = reg21;
      ex_d.write_reg  = writeReg;
      ex_d.branch     = Branch;
      ex_d.mem_read   = MemRead;
      ex_d.mem_write  = MemWrite;
      ex_d.reg_write  = RegWrite;
      ex_d.memto_reg  = MemtoReg;
    end
  end

  // Stalled edges push a bubble downstream; the data fields simply hold.
  always_comb begin
    wb_d = wb_q;
    if (stall_c) begin
      wb_d.reg_write  = 1'b0;
      wb_d.memto_reg  = 1'b0;
      wb_d.misaligned = 1'b0;
    end else begin
      wb_d.read_data  = (ex_q.mem_read && !fault) ? ram_rdata : 32'h0;
      wb_d.alu_res    = ex_q.alu_res;
      wb_d.write_reg  = ex_q.write_reg;
      wb_d.reg_write  = ex_q.reg_write & ~fault;
      wb_d.memto_reg  = ex_q.memto_reg;
      wb_d.misaligned = fault;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_q    <= '0;
      wb_q    <= '0;
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      ex_q    <= ex_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram[word_addr] <= ex_q.reg21;
    end
  end

  assign stall        = stall_c;
  assign pcSrc        = ex_q.branch & ex_q.zero;
  assign branchTarget = ex_q.branch_adr;
  assign readData     = wb_q.read_data;
  assign aluResOut    = wb_q.alu_res;
  assign writeRegOut  = wb_q.write_reg;
  assign RegWriteOut  = wb_q.reg_write;
  assign MemtoRegOut  = wb_q.memto_reg;
  assign misaligned   = wb_q.misaligned;

endmodule
